// File: rtl/intra_filter_sum_pipe.sv
// Intra angular filter tail: sums four tap products, rounds (+32)>>6, clips, and tags block ends.
// Optional INTRA_FILTER_CLIP_CNT_EN adds a saturating clip_cnt output.
module intra_filter_sum_pipe #(
   parameter int BIT_DEPTH     = 8,
   parameter int BLOCK_SAMPLES = 16,
   parameter int CNT_W         = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [15:0]   in_p0,
   input  logic signed [15:0]   in_p1,
   input  logic signed [15:0]   in_p2,
   input  logic signed [15:0]   in_p3,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_DEPTH-1:0] out_pred,
`ifdef INTRA_FILTER_CLIP_CNT_EN
   output logic [15:0]          clip_cnt,
`endif
   output logic                 out_last
);

   localparam logic signed [17:0] MAXV = 18'((1 << BIT_DEPTH) - 1);
   localparam logic [CNT_W-1:0]   LAST = CNT_W'(BLOCK_SAMPLES - 1);

   logic [3:1]              r_vld_pipe;
   logic signed [16:0]      r_s1a, r_s1b;
   logic signed [17:0]      r_s2;
   logic [BIT_DEPTH-1:0]    r_pred;
   logic [CNT_W-1:0]        r_cnt;

   logic                    w_s1_en, w_s2_en, w_s3_en, w_out_xfer;
   logic signed [17:0]      w_r;
   logic                    w_neg, w_hi;
   logic [BIT_DEPTH-1:0]    w_pred;

   // A stage loads when it is empty or its content moves on this cycle.
   assign w_s3_en    = !r_vld_pipe[3] || out_ready;
   assign w_s2_en    = !r_vld_pipe[2] || w_s3_en;
   assign w_s1_en    = !r_vld_pipe[1] || w_s2_en;
   assign w_out_xfer = r_vld_pipe[3] && out_ready;

   assign in_ready  = w_s1_en && !clear;
   assign out_valid = r_vld_pipe[3];
   assign out_pred  = r_pred;
   assign out_last  = r_vld_pipe[3] && (r_cnt == LAST);

   assign w_r    = r_s2 >>> 6;
   assign w_neg  = w_r[17];
   assign w_hi   = !w_neg && (w_r > MAXV);
   assign w_pred = w_neg ? '0 : (w_hi ? {BIT_DEPTH{1'b1}} : w_r[BIT_DEPTH-1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_pipe <= '0;
         r_s1a      <= '0;
         r_s1b      <= '0;
         r_s2       <= '0;
         r_pred     <= '0;
         r_cnt      <= '0;
      end else if (clear) begin
         r_vld_pipe <= '0;
         r_cnt      <= '0;
      end else begin
         if (w_s1_en) begin
            r_vld_pipe[1] <= in_valid;
            if (in_valid) begin
               r_s1a <= 17'(in_p0) + 17'(in_p1);
               r_s1b <= 17'(in_p2) + 17'(in_p3);
            end
         end
         if (w_s2_en) begin
            r_vld_pipe[2] <= r_vld_pipe[1];
            if (r_vld_pipe[1])
               r_s2 <= 18'(r_s1a) + 18'(r_s1b) + 18'sd32;
         end
         if (w_s3_en) begin
            r_vld_pipe[3] <= r_vld_pipe[2];
            if (r_vld_pipe[2])
               r_pred <= w_pred;
         end
         // Counting at the output keeps the block tag immune to stalls.
         if (w_out_xfer)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
      end
   end

`ifdef INTRA_FILTER_CLIP_CNT_EN
   logic        r_s3_clip;
   logic [15:0] r_clip_cnt;

   assign clip_cnt = r_clip_cnt;

   // The clip flag rides alongside r_pred so it retires with its own sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s3_clip  <= 1'b0;
         r_clip_cnt <= '0;
      end else if (clear) begin
         r_clip_cnt <= '0;
      end else begin
         if (w_s3_en && r_vld_pipe[2])
            r_s3_clip <= w_neg || w_hi;
         if (w_out_xfer && r_s3_clip && (r_clip_cnt != 16'hFFFF))
            r_clip_cnt <= r_clip_cnt + 16'd1;
      end
   end
`endif

endmodule
